muldiv_unit: RTL
================

# muldiv_unit

Iterative RV32M multiply/divide unit, parametrised in datapath width, sitting beside `alu` in the execute stage. It accepts one operation through a valid/ready handshake, computes it over multiple cycles, and holds the result on a valid/ready output until the pipeline consumes it. It covers all eight M-extension operations, including the architected divide-by-zero and signed-overflow results, and supports a pipeline flush that abandons work in progress.

## Interface
Parameters:
- `XLEN`, 32: operand and result width; must be ≥ 4 and even.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high reset.
- `flush` in 1: abandons any operation in progress or pending.
- `in_valid` in 1: an operation is offered.
- `in_ready` out 1: the unit can accept an operation.
- `op` in 3: `md_op_t` from `common`.
- `left_operand` in XLEN: rs1 value.
- `right_operand` in XLEN: rs2 value.
- `out_valid` out 1: `result` is valid.
- `out_ready` in 1: the consumer takes the result.
- `result` out XLEN: the operation result.
- `busy` out 1: the unit is in state MUL or DIV.

## Operation
- Operations, low XLEN bits unless stated:
  - MUL: low half of the product.
  - MULH: high half, signed × signed.
  - MULHSU: high half, signed × unsigned.
  - MULHU: high half, unsigned × unsigned.
  - DIV, DIVU: quotient, truncated toward zero.
  - REM, REMU: remainder; its sign follows the dividend.
- States and transitions:
  - IDLE → MUL or DIV on an accepted operation.
  - MUL/DIV → DONE after the iteration count reaches XLEN.
  - DONE → IDLE when `out_ready` is high.
  - Any state → IDLE on `flush`.
- Operand capture:
  - An operation is accepted when `in_valid && in_ready`.
  - At acceptance, operand magnitudes, the result-sign flags and `op` are registered.
  - Later changes on the input ports have no effect on the operation.
- Multiply:
  - Radix-2 shift-add over a 2·XLEN accumulator, one bit per cycle.
  - Sign correction is applied in the final iteration cycle; it does not add a cycle.
- Divide:
  - Restoring division, one quotient bit per cycle.
  - Quotient and remainder signs are fixed in the final iteration cycle.
- Special cases bypass the iteration and go from IDLE straight to DONE:
  - Divisor == 0: DIV/DIVU return all-ones; REM/REMU return the dividend.
  - DIV/REM with dividend == 1 followed by XLEN−1 zeros and divisor == all-ones (the signed overflow case): DIV returns the dividend; REM returns 0.
- `result` is registered and updates only on entry to DONE.
- `in_ready` is high only in IDLE and never while `flush` is high.

## Timing
- Reset values: state IDLE, `in_ready` 1, `out_valid` 0, `busy` 0, `result` 0.
- Latency, with acceptance in cycle T:
  - Iterative operations: `out_valid` is high from T+XLEN+1.
  - Special cases: `out_valid` is high from T+1.
- `out_valid` and `result` stay stable until `out_ready` is sampled high.
- `in_ready` rises in the cycle after the result handshake; there is no back-to-back overlap.
- Flush:
  - `flush` wins over a simultaneous `in_valid`; that operation is not accepted.
  - `flush` wins over a simultaneous `out_ready` in DONE; the result is dropped.
  - The unit is back in IDLE the next cycle with `out_valid` 0.
- `reset` mid-operation behaves like `flush` and also clears `result` to 0.
- `op` encodings outside the defined set are treated as MUL.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - All multiply ops use a single-cycle 2·XLEN combinational product.
  - They go IDLE → DONE with `out_valid` at T+1.
  - State MUL is never entered.
- Undefined: multiply ops use the iterative path with `out_valid` at T+XLEN+1.
- Divide behaviour is identical in both builds.

## Structure
- Package `common` gains:
  - `md_op_t`, encoding 0–7 in the order MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - `md_state_t` (IDLE, MUL, DIV, DONE).
- One sub-module, `muldiv_div_step`: a combinational single restoring-division iteration (partial remainder and divisor in; next remainder and quotient bit out), instantiated once.

## Test plan
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; `out_valid` at T+33 (T+1 with `MULDIV_FAST_MUL_EN`).
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0; each with `out_valid` at T+1.
- Backpressure: hold `out_ready` low for 5 cycles after `out_valid` → `result` stable and `in_ready` 0 throughout; `in_ready` 1 the cycle after the handshake.
- Flush at cycle T+10 of a DIV → IDLE at T+11 with `out_valid` never asserted; a following MUL 3 × 4 → 12.
- Reset asserted in DONE → `out_valid` 0 and `result` 0 the next cycle; `flush` and `in_valid` in the same cycle → nothing accepted.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// ---------------------------------------------------------------------------
// common : shared types for the execute-stage arithmetic units.
//
// md_op_t    : M-extension operation code carried on the muldiv_unit op port.
// md_state_t : control states of the iterative multiply/divide unit.
// Helper functions classify which operands of an op are read as signed.
// ---------------------------------------------------------------------------
package common;

   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } md_state_t;

   // rs1 is two's complement for MULH, MULHSU, DIV and REM
   function automatic logic lhs_signed(md_op_t op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is two's complement for MULH, DIV and REM
   function automatic logic rhs_signed(md_op_t op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_unit_div_step.sv
// ---------------------------------------------------------------------------
// muldiv_div_step : one combinational restoring-division iteration.
//
// Ports:
//   partial  in  XLEN+1 : shifted partial remainder {remainder, next dividend bit}
//   divisor  in  XLEN   : divisor magnitude
//   rem_next out XLEN   : remainder after this iteration
//   q_bit    out 1      : quotient bit produced by this iteration
// ---------------------------------------------------------------------------
module muldiv_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   partial,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] rem_next,
   output logic            q_bit
);

   logic [XLEN:0] diff;

   // The running remainder is always below the divisor, so partial is below
   // twice the divisor and the difference fits XLEN+1 bits as a signed value:
   // its top bit is a clean borrow flag.
   always_comb begin
      diff     = partial - {1'b0, divisor};
      q_bit    = ~diff[XLEN];
      rem_next = q_bit ? diff[XLEN-1:0] : partial[XLEN-1:0];
   end

endmodule

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative RV32M multiply/divide unit for the execute stage.
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   flush               : abandon any operation in progress or pending
//   in_valid / in_ready : operation handshake (op, left_operand, right_operand)
//   out_valid/ out_ready: result handshake (result)
//   busy                : unit is iterating (state MUL or DIV)
//
// Build option: define MULDIV_FAST_MUL_EN to compute all multiplies with a
// single-cycle combinational product instead of the shift-add iteration.
// ---------------------------------------------------------------------------
module muldiv_unit
   import common::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] left_operand,
   input  logic [XLEN-1:0] right_operand,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN);
   localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

   md_state_t         state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;
   md_op_t            op_q, op_d;
   logic              neg_q, neg_d;
   logic              rem_neg_q, rem_neg_d;
   logic [XLEN-1:0]   result_q, result_d;

   md_op_t            op_in;
   logic              lhs_neg, rhs_neg;
   logic [XLEN-1:0]   lhs_mag, rhs_mag;
   logic              is_final;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next, mul_fixed;
   logic [XLEN-1:0]   rem_next;
   logic              q_bit;
   logic [2*XLEN-1:0] div_next;
   logic [XLEN-1:0]   quot_fixed, rem_fixed;
`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod, fast_fixed;
`endif

   assign op_in     = md_op_t'(op);
   assign in_ready  = (state_q == S_IDLE) && !flush;
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q == S_MUL) || (state_q == S_DIV);
   assign result    = result_q;

   // Accumulator layout while dividing: {remainder, dividend/quotient}.
   muldiv_div_step #(.XLEN(XLEN)) u_div_step (
      .partial  (acc_q[2*XLEN-1:XLEN-1]),
      .divisor  (opnd_q),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   // Both datapaths work on magnitudes; the sign of the result is restored
   // combinationally in the last iteration so no extra cycle is spent.
   always_comb begin
      lhs_neg  = lhs_signed(op_in) && left_operand[XLEN-1];
      rhs_neg  = rhs_signed(op_in) && right_operand[XLEN-1];
      lhs_mag  = lhs_neg ? -left_operand : left_operand;
      rhs_mag  = rhs_neg ? -right_operand : right_operand;
      is_final = (count_q == CW'(XLEN-1));

      // Shift-add: the multiplier sits in the low half and is consumed LSB first.
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opnd_q};
      mul_next  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
      mul_fixed = neg_q ? -mul_next : mul_next;

      div_next   = {rem_next, acc_q[XLEN-2:0], q_bit};
      quot_fixed = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
      rem_fixed  = rem_neg_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];

`ifdef MULDIV_FAST_MUL_EN
      fast_prod  = {{XLEN{1'b0}}, lhs_mag} * {{XLEN{1'b0}}, rhs_mag};
      fast_fixed = (lhs_neg ^ rhs_neg) ? -fast_prod : fast_prod;
`endif
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      op_d      = op_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      result_d  = result_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready) begin
               op_d    = op_in;
               count_d = '0;
               if (op_in[2]) begin
                  if (right_operand == '0) begin
                     result_d = op_in[1] ? left_operand : {XLEN{1'b1}};
                     state_d  = S_DONE;
                  end else if (lhs_signed(op_in) && left_operand == SIGNED_MIN &&
                               right_operand == {XLEN{1'b1}}) begin
                     // Signed overflow: the quotient wraps to the dividend.
                     result_d = op_in[1] ? {XLEN{1'b0}} : left_operand;
                     state_d  = S_DONE;
                  end else begin
                     acc_d     = {{XLEN{1'b0}}, lhs_mag};
                     opnd_d    = rhs_mag;
                     neg_d     = lhs_neg ^ rhs_neg;
                     rem_neg_d = lhs_neg;
                     state_d   = S_DIV;
                  end
               end else begin
`ifdef MULDIV_FAST_MUL_EN
                  result_d = (op_in == MD_MUL) ? fast_fixed[XLEN-1:0] : fast_fixed[2*XLEN-1:XLEN];
                  state_d  = S_DONE;
`else
                  acc_d   = {{XLEN{1'b0}}, rhs_mag};
                  opnd_d  = lhs_mag;
                  neg_d   = lhs_neg ^ rhs_neg;
                  state_d = S_MUL;
`endif
               end
            end
         end
         S_MUL: begin
            acc_d   = mul_next;
            count_d = count_q + CW'(1);
            if (is_final) begin
               result_d = (op_q == MD_MUL) ? mul_fixed[XLEN-1:0] : mul_fixed[2*XLEN-1:XLEN];
               state_d  = S_DONE;
            end
         end
         S_DIV: begin
            acc_d   = div_next;
            count_d = count_q + CW'(1);
            if (is_final) begin
               result_d = op_q[1] ? rem_fixed : quot_fixed;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // A flush overrides everything, including a result that would be
      // written on this very edge.
      if (flush) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   // State and datapath registers; reset also clears the visible result.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         op_q      <= MD_MUL;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         op_q      <= op_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         result_q  <= result_d;
      end
   end

endmodule
